mem_req_ctrl: RTL and testbench

Request controller that sits directly upstream of the single-port `memory` SRAM wrapper. It accepts independent write and read request streams (valid/ready), arbitrates them onto the memory's one-access-per-cycle port, and tracks the wrapper's fixed 1-cycle read latency. Read data is collected into a first-word-fall-through response FIFO with backpressure, so downstream consumers never lose data.

---
 rtl/mem_req_ctrl_if.sv | 41 ++++
 rtl/mem_req_ctrl.sv | 82 ++++++++
 tb/tb_mem_req_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_if.sv
// Request/response and memory-side signals of mem_req_ctrl.
// The slave modport is the controller; master is the client plus memory wrapper.
interface mem_req_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              wr_req_vld_i;
  logic [ADDR_W-1:0] wr_req_addr_i;
  logic [DATA_W-1:0] wr_req_data_i;
  logic              wr_req_rdy_o;
  logic              rd_req_vld_i;
  logic [ADDR_W-1:0] rd_req_addr_i;
  logic              rd_req_rdy_o;
  logic              rd_rsp_vld_o;
  logic [DATA_W-1:0] rd_rsp_data_o;
  logic              rd_rsp_rdy_i;
  logic              mem_wr_vld_o;
  logic [DATA_W-1:0] mem_wr_data_o;
  logic [ADDR_W-1:0] mem_wr_addr_o;
  logic              mem_rd_vld_o;
  logic [ADDR_W-1:0] mem_rd_addr_o;
  logic              mem_wr_rdy_i;
  logic [DATA_W-1:0] mem_rd_data_i;
  logic              mem_rd_rdy_i;

  modport slave (
    input  wr_req_vld_i, wr_req_addr_i, wr_req_data_i,
    input  rd_req_vld_i, rd_req_addr_i, rd_rsp_rdy_i,
    input  mem_wr_rdy_i, mem_rd_data_i, mem_rd_rdy_i,
    output wr_req_rdy_o, rd_req_rdy_o, rd_rsp_vld_o, rd_rsp_data_o,
    output mem_wr_vld_o, mem_wr_data_o, mem_wr_addr_o, mem_rd_vld_o, mem_rd_addr_o
  );

  modport master (
    output wr_req_vld_i, wr_req_addr_i, wr_req_data_i,
    output rd_req_vld_i, rd_req_addr_i, rd_rsp_rdy_i,
    output mem_wr_rdy_i, mem_rd_data_i, mem_rd_rdy_i,
    input  wr_req_rdy_o, rd_req_rdy_o, rd_rsp_vld_o, rd_rsp_data_o,
    input  mem_wr_vld_o, mem_wr_data_o, mem_wr_addr_o, mem_rd_vld_o, mem_rd_addr_o
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Arbitrates write/read requests onto a single-port SRAM (1-cycle read latency);
// reads return 2 cycles after acceptance through a FWFT FIFO; reads stall on FIFO credit.
module mem_req_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_req_ctrl_if.slave  bus
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 2;

  logic              prio, prio_nxt;
  logic              inflight, inflight_nxt;
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       occ;
  logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];
  logic [CW-1:0]     pending;
  logic              write_ok, read_ok, wr_gnt, rd_gnt, push, pop, not_empty;

  always_comb begin
    pending  = {1'b0, occ} + {{(PW + 1){1'b0}}, inflight};
    write_ok = bus.wr_req_vld_i & bus.mem_wr_rdy_i;
    // Credit counts the read still in the memory pipe; pops give no same-cycle credit.
    read_ok  = bus.rd_req_vld_i & (pending < CW'(RSP_DEPTH));
    wr_gnt   = 1'b0;
    rd_gnt   = 1'b0;
    prio_nxt = prio;
    if (write_ok && read_ok) begin
      if (prio) rd_gnt = 1'b1;
      else      wr_gnt = 1'b1;
      prio_nxt = ~prio;
    end else begin
      wr_gnt = write_ok;
      rd_gnt = read_ok;
    end
    if (!rst_n) begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
    end
    not_empty    = (occ != '0);
    push         = bus.mem_rd_rdy_i & inflight;
    pop          = not_empty & bus.rd_rsp_rdy_i;
    inflight_nxt = rd_gnt | (inflight & ~bus.mem_rd_rdy_i);
  end

  assign bus.wr_req_rdy_o  = wr_gnt;
  assign bus.rd_req_rdy_o  = rd_gnt;
  assign bus.mem_wr_vld_o  = wr_gnt;
  assign bus.mem_rd_vld_o  = rd_gnt;
  assign bus.mem_wr_data_o = bus.wr_req_data_i;
  assign bus.mem_wr_addr_o = rd_gnt ? bus.rd_req_addr_i : bus.wr_req_addr_i;
  assign bus.mem_rd_addr_o = bus.mem_wr_addr_o;
  assign bus.rd_rsp_vld_o  = not_empty;
  assign bus.rd_rsp_data_o = not_empty ? rsp_mem[rptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio     <= 1'b0;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
    end else begin
      prio     <= prio_nxt;
      inflight <= inflight_nxt;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) rsp_mem[wptr] <= bus.mem_rd_data_i;
  end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural 1-cycle-latency SRAM model.
module tb_mem_req_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_req_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  mem_req_ctrl #(.DATA_W(8), .ADDR_W(8), .RSP_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // SRAM model: preloaded with data = address on the first edge.
  logic [7:0] mdl [256];
  logic       mdl_rdy   = 1'b0;
  logic [7:0] mdl_q     = 8'h00;
  logic       init_done = 1'b0;
  logic       stray     = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mdl[i] <= 8'(i);
      init_done <= 1'b1;
    end else if (bus.mem_wr_vld_o && bus.mem_wr_rdy_i) begin
      mdl[bus.mem_wr_addr_o] <= bus.mem_wr_data_o;
    end
    mdl_rdy <= bus.mem_rd_vld_o;
    mdl_q   <= mdl[bus.mem_rd_addr_o];
  end

  assign bus.mem_rd_rdy_i  = mdl_rdy | stray;
  assign bus.mem_rd_data_i = mdl_q;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.wr_req_vld_i = 1'b0;
    bus.rd_req_vld_i = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int k;

  initial begin
    bus.wr_req_vld_i  = 1'b1;
    bus.wr_req_addr_i = 8'h00;
    bus.wr_req_data_i = 8'h00;
    bus.rd_req_vld_i  = 1'b1;
    bus.rd_req_addr_i = 8'h00;
    bus.rd_rsp_rdy_i  = 1'b1;
    bus.mem_wr_rdy_i  = 1'b1;

    // Reset state with both requests asserted
    tick();
    tick();
    @(negedge clk);
    check("rst_wr_rdy",  32'(bus.wr_req_rdy_o), 0);
    check("rst_rd_rdy",  32'(bus.rd_req_rdy_o), 0);
    check("rst_mwr_vld", 32'(bus.mem_wr_vld_o), 0);
    check("rst_mrd_vld", 32'(bus.mem_rd_vld_o), 0);
    check("rst_rsp_vld", 32'(bus.rd_rsp_vld_o), 0);
    check("rst_rsp_dat", 32'(bus.rd_rsp_data_o), 0);
    idle();
    tick();
    rst_n = 1'b1;

    // Single write 0x12 <- 0xA5, then read it back
    bus.wr_req_vld_i = 1'b1; bus.wr_req_addr_i = 8'h12; bus.wr_req_data_i = 8'hA5;
    @(negedge clk);
    check("t1_wr_rdy",   32'(bus.wr_req_rdy_o), 1);
    check("t1_mwr_vld",  32'(bus.mem_wr_vld_o), 1);
    check("t1_mwr_addr", 32'(bus.mem_wr_addr_o), 32'h12);
    check("t1_mwr_data", 32'(bus.mem_wr_data_o), 32'hA5);
    check("t1_mrd_vld",  32'(bus.mem_rd_vld_o), 0);
    tick();
    idle();
    bus.rd_req_vld_i = 1'b1; bus.rd_req_addr_i = 8'h12;
    @(negedge clk);
    check("t1_rd_rdy",   32'(bus.rd_req_rdy_o), 1);
    check("t1_mrd_vld",  32'(bus.mem_rd_vld_o), 1);
    check("t1_mrd_addr", 32'(bus.mem_rd_addr_o), 32'h12);
    check("t1_maddr_eq", 32'(bus.mem_wr_addr_o), 32'h12);
    check("t1_mwr_vld0", 32'(bus.mem_wr_vld_o), 0);
    tick();
    idle();
    @(negedge clk);
    check("t1_rsp_n1", 32'(bus.rd_rsp_vld_o), 0);
    tick();
    @(negedge clk);
    check("t1_rsp_vld", 32'(bus.rd_rsp_vld_o), 1);
    check("t1_rsp_dat", 32'(bus.rd_rsp_data_o), 32'hA5);
    tick();
    @(negedge clk);
    check("t1_rsp_pop", 32'(bus.rd_rsp_vld_o), 0);

    // Contention from reset: strict alternation W,R,W,R,W,R
    do_reset();
    bus.wr_req_vld_i = 1'b1; bus.wr_req_addr_i = 8'h30; bus.wr_req_data_i = 8'h5A;
    bus.rd_req_vld_i = 1'b1; bus.rd_req_addr_i = 8'h40;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t2_wr_rdy%0d", i), 32'(bus.wr_req_rdy_o), (i % 2 == 0) ? 1 : 0);
      check($sformatf("t2_rd_rdy%0d", i), 32'(bus.rd_req_rdy_o), (i % 2 == 1) ? 1 : 0);
      tick();
    end
    idle();
    repeat (3) tick();

    // Credit limit: consumer stalled, 8 read attempts, only 4 accepted
    bus.rd_rsp_rdy_i = 1'b0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      bus.rd_req_vld_i = 1'b1; bus.rd_req_addr_i = 8'(k);
      @(negedge clk);
      if (bus.rd_req_rdy_o) k++;
      tick();
    end
    check("t3_accepts", 32'(k), 4);
    @(negedge clk);
    check("t3_stall", 32'(bus.rd_req_rdy_o), 0);
    tick();
    idle();
    bus.rd_rsp_rdy_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("t3_drain_vld%0d", j), 32'(bus.rd_rsp_vld_o), 1);
      check($sformatf("t3_drain_dat%0d", j), 32'(bus.rd_rsp_data_o), 32'(j));
      tick();
    end
    @(negedge clk);
    check("t3_empty", 32'(bus.rd_rsp_vld_o), 0);
    bus.rd_req_vld_i = 1'b1; bus.rd_req_addr_i = 8'h04;
    @(negedge clk);
    check("t3_resume", 32'(bus.rd_req_rdy_o), 1);
    tick();
    idle();
    repeat (3) tick();

    // Streaming: 16 reads of 0..15, one per cycle, responses 2 cycles later
    for (int c = 0; c < 18; c++) begin
      bus.rd_req_vld_i  = (c < 16);
      bus.rd_req_addr_i = 8'(c);
      @(negedge clk);
      if (c < 16) check($sformatf("t4_acc%0d", c), 32'(bus.rd_req_rdy_o), 1);
      if (c >= 2) begin
        check($sformatf("t4_rsp_vld%0d", c - 2), 32'(bus.rd_rsp_vld_o), 1);
        check($sformatf("t4_rsp_dat%0d", c - 2), 32'(bus.rd_rsp_data_o), 32'(c - 2));
      end
      tick();
    end
    idle();
    @(negedge clk);
    check("t4_done", 32'(bus.rd_rsp_vld_o), 0);
    tick();

    // Memory refuses writes: reads still flow
    bus.mem_wr_rdy_i = 1'b0;
    bus.wr_req_vld_i = 1'b1; bus.wr_req_addr_i = 8'h50; bus.wr_req_data_i = 8'h11;
    for (int i = 0; i < 2; i++) begin
      bus.rd_req_vld_i = 1'b1; bus.rd_req_addr_i = 8'(5 + i);
      @(negedge clk);
      check($sformatf("t5_wr_rdy%0d", i),  32'(bus.wr_req_rdy_o), 0);
      check($sformatf("t5_mwr_vld%0d", i), 32'(bus.mem_wr_vld_o), 0);
      check($sformatf("t5_rd_rdy%0d", i),  32'(bus.rd_req_rdy_o), 1);
      check($sformatf("t5_maddr%0d", i),   32'(bus.mem_wr_addr_o), 32'(5 + i));
      tick();
    end
    bus.rd_req_vld_i = 1'b0;
    bus.mem_wr_rdy_i = 1'b1;
    @(negedge clk);
    check("t5_wr_go", 32'(bus.wr_req_rdy_o), 1);
    check("t5_mwr_addr", 32'(bus.mem_wr_addr_o), 32'h50);
    tick();
    idle();
    repeat (3) tick();

    // Reset one cycle after a read grant; stray memory valid afterwards
    bus.rd_req_vld_i = 1'b1; bus.rd_req_addr_i = 8'h07;
    @(negedge clk);
    check("t6_rd_rdy", 32'(bus.rd_req_rdy_o), 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_rd_rdy", 32'(bus.rd_req_rdy_o), 0);
    check("t6_rst_rsp", 32'(bus.rd_rsp_vld_o), 0);
    tick();
    idle();
    rst_n = 1'b1;
    stray = 1'b1;
    @(negedge clk);
    check("t6_rel_rsp", 32'(bus.rd_rsp_vld_o), 0);
    tick();
    stray = 1'b0;
    @(negedge clk);
    check("t6_stray_ign", 32'(bus.rd_rsp_vld_o), 0);
    tick();
    @(negedge clk);
    check("t6_still_empty", 32'(bus.rd_rsp_vld_o), 0);
    bus.rd_req_vld_i = 1'b1; bus.rd_req_addr_i = 8'h12;
    @(negedge clk);
    check("t6_post_rd", 32'(bus.rd_req_rdy_o), 1);
    tick();
    idle();
    tick();
    @(negedge clk);
    check("t6_post_vld", 32'(bus.rd_rsp_vld_o), 1);
    check("t6_post_dat", 32'(bus.rd_rsp_data_o), 32'hA5);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
